parity_page_collector: RTL and testbench
========================================

// Module: parity_page_collector
// PURPOSE
//  Receive end of the column-parity result stream. Captures one WIDTH-bit word per Done pulse
//  from the ColParity engine and stores it in page order (0..PAGES-1) in a local buffer.
//  Gives the downstream Keccak stage a registered random-access read port and a running XOR checksum.
//  Sits between ColParity (Out/Done) and the next permutation step or the file-dump logic.
// PARAMETERS
//  WIDTH   25   bits per page word (5x5 slice)
//  PAGES   64   pages per frame (lanes)
//  IDX_W   6    index width, clog2(PAGES)
// PORTS
//  clk         in   1        system clock, all logic on rising edge
//  reset       in   1        synchronous, active-high
//  start       in   1        level; rising edge arms a new frame
//  in_data     in   WIDTH    result word (ColParity Out)
//  in_done     in   1        result strobe (ColParity Done); level, may stay high >1 cycle
//  rd_index    in   IDX_W    read address
//  rd_data     out  WIDTH    buffer[rd_index], registered
//  page_count  out  IDX_W+1  pages captured in current frame, 0..PAGES
//  checksum    out  WIDTH    XOR of all words captured in current frame
//  full        out  1        all PAGES words captured
//  busy        out  1        collecting (armed, not yet full)
//  overrun     out  1        sticky: capture edge seen while not armed
// BEHAVIOUR
//  Reset: state=IDLE; page_count=0, checksum=0, full=0, busy=0, overrun=0, rd_data=0;
//   buffer contents are not cleared.
//  Edge detect: registered copies of start and in_done. Event = cur & ~prev.
//   A Done held high for N cycles yields exactly one capture.
//  States:
//   IDLE    -> COLLECT on start edge: page_count=0, checksum=0, overrun=0, busy=1, full=0
//   COLLECT -> on done edge: buffer[page_count]<=in_data; checksum^=in_data; page_count+=1.
//              Capture uses in_data in the edge cycle (cur=1, prev=0).
//              When the captured page is PAGES-1: go to FULL, full=1, busy=0 next cycle.
//   FULL    -> start edge re-arms exactly as from IDLE; done edge sets overrun=1, buffer untouched.
//  IDLE + done edge: overrun=1, no write.
//  Start edge in COLLECT (restart mid-frame): page_count=0, checksum=0, stay in COLLECT.
//   Stale words from the old frame remain in the buffer until overwritten.
//  Simultaneous start edge and done edge: start wins, the word is dropped, page_count=0.
//  Read port: rd_data <= buffer[rd_index] every cycle, 1-cycle latency.
//   Read-during-write at the same index returns the OLD word (read-first).
//  page_count saturates at PAGES and never wraps; the write index is page_count[IDX_W-1:0].
//  Reset asserted mid-frame aborts immediately to IDLE with the reset values above.
//  full and busy are never both 1. overrun clears only on reset or start edge.
// STRUCTURE
//  Shared package: WIDTH/PAGES/IDX_W defaults; state encoding IDLE=2'd0, COLLECT=2'd1, FULL=2'd2.
//  One sub-module: page_buffer_1r1w (PAGES x WIDTH, sync write, registered read-first read).
//  The top holds the FSM, edge detectors, counter and checksum.
// TESTING
//  1 reset, start edge, 64 Done pulses (1 cycle each, word=i) -> full=1 at pulse 64; page_count=64;
//    checksum=0; rd_index=5 gives rd_data=5 one cycle later.
//  2 Done held high 4 cycles per page, 64 pages of 25'h1FFFFFF -> exactly 64 captures;
//    checksum=0; overrun=0.
//  3 in FULL, one extra Done pulse -> overrun=1; page_count stays 64; buffer unchanged;
//    next start edge clears overrun, full=0.
//  4 start edge after 10 pages -> page_count=0, checksum=0; next word lands at index 0.
//  5 start edge and Done edge in the same cycle -> page_count=0; word not stored;
//    Done edge in IDLE before any start -> overrun=1.
//  6 reset asserted at page 30 -> all outputs at reset values next cycle; state IDLE;
//    rd_index=3 still returns the old word.

Source files
------------

// File: rtl/parity_page_collector_pkg.sv
// Shared defaults and state encoding for the parity page collector slice.
package parity_page_collector_pkg;

    localparam int DEF_WIDTH = 25;   // bits per page word (5x5 slice)
    localparam int DEF_PAGES = 64;   // pages per frame
    localparam int DEF_IDX_W = 6;    // clog2(DEF_PAGES)

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

endpackage

// File: rtl/parity_page_collector_buffer.sv
// Page store: one synchronous write port, one registered read-first read port.
module page_buffer_1r1w #(
    parameter int WIDTH  = 25,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; a same-cycle write to rd_addr is not visible (old word returned).
    always_ff @(posedge clk) begin
        if (srst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/parity_page_collector.sv
// Collects one ColParity result word per Done edge into a page buffer,
// tracks page count and a running XOR checksum, and flags captures while unarmed.
module parity_page_collector
    import parity_page_collector_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PAGES = DEF_PAGES,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_done,
    input  logic [IDX_W-1:0] rd_index,
    output logic [WIDTH-1:0] rd_data,
    output logic [IDX_W:0]   page_count,
    output logic [WIDTH-1:0] checksum,
    output logic             full,
    output logic             busy,
    output logic             overrun
);

    localparam logic [IDX_W:0] LAST_PAGE = (IDX_W+1)'(PAGES - 1);
    localparam logic [IDX_W:0] MAX_COUNT = (IDX_W+1)'(PAGES);

    logic             start_prev_reg;
    logic             done_prev_reg;
    logic             start_edge;
    logic             done_edge;
    logic [1:0]       state_reg, state_next;
    logic [IDX_W:0]   count_reg, count_next;
    logic [WIDTH-1:0] checksum_reg, checksum_next;
    logic             overrun_reg, overrun_next;
    logic             wr_en;

    assign start_edge = start & ~start_prev_reg;
    assign done_edge  = in_done & ~done_prev_reg;

    // Previous-cycle copies of the level inputs for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_prev_reg <= 1'b0;
            done_prev_reg  <= 1'b0;
        end else begin
            start_prev_reg <= start;
            done_prev_reg  <= in_done;
        end
    end

    // Next-state logic: a start edge always wins over a coincident done edge.
    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        checksum_next = checksum_reg;
        overrun_next  = overrun_reg;
        wr_en         = 1'b0;
        if (start_edge) begin
            state_next    = ST_COLLECT;
            count_next    = '0;
            checksum_next = '0;
            overrun_next  = 1'b0;
        end else if (done_edge) begin
            if (state_reg == ST_COLLECT && count_reg < MAX_COUNT) begin
                wr_en         = 1'b1;
                checksum_next = checksum_reg ^ in_data;
                count_next    = count_reg + 1'b1;
                if (count_reg == LAST_PAGE) begin
                    state_next = ST_FULL;
                end
            end else begin
                overrun_next = 1'b1;
            end
        end
    end

    // FSM, counter, checksum and sticky overrun registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            count_reg    <= '0;
            checksum_reg <= '0;
            overrun_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            checksum_reg <= checksum_next;
            overrun_reg  <= overrun_next;
        end
    end

    page_buffer_1r1w #(
        .WIDTH  (WIDTH),
        .DEPTH  (PAGES),
        .ADDR_W (IDX_W)
    ) u_buffer (
        .clk     (clk),
        .srst    (reset),
        .wr_en   (wr_en),
        .wr_addr (count_reg[IDX_W-1:0]),
        .wr_data (in_data),
        .rd_addr (rd_index),
        .rd_data (rd_data)
    );

    assign page_count = count_reg;
    assign checksum   = checksum_reg;
    assign overrun    = overrun_reg;
    assign full       = (state_reg == ST_FULL);
    assign busy       = (state_reg == ST_COLLECT);

endmodule

// File: tb/tb_parity_page_collector.sv
// Directed bench for parity_page_collector with a cycle model and a read-data scoreboard.
module tb_parity_page_collector;

    localparam int WIDTH = 25;
    localparam int PAGES = 64;
    localparam int IDX_W = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] in_data;
    logic             in_done;
    logic [IDX_W-1:0] rd_index;
    logic [WIDTH-1:0] rd_data;
    logic [IDX_W:0]   page_count;
    logic [WIDTH-1:0] checksum;
    logic             full;
    logic             busy;
    logic             overrun;

    parity_page_collector dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_data    (in_data),
        .in_done    (in_done),
        .rd_index   (rd_index),
        .rd_data    (rd_data),
        .page_count (page_count),
        .checksum   (checksum),
        .full       (full),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state (0=idle, 1=collect, 2=full)
    logic [WIDTH-1:0] m_mem [PAGES];
    int               m_state;
    int               m_cnt;
    logic [WIDTH-1:0] m_cs;
    logic             m_ov;
    logic             m_ps;
    logic             m_pd;
    logic [WIDTH-1:0] rd_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model from the driven inputs, queue the expected
    // read word, clock the DUT and compare the registered read data.
    task automatic step();
        logic [WIDTH-1:0] exp_rd;
        logic             se;
        logic             de;
        logic [WIDTH-1:0] got;
        if (reset) begin
            exp_rd  = '0;
            m_state = 0;
            m_cnt   = 0;
            m_cs    = '0;
            m_ov    = 1'b0;
            m_ps    = 1'b0;
            m_pd    = 1'b0;
        end else begin
            exp_rd = m_mem[rd_index];
            se = start & ~m_ps;
            de = in_done & ~m_pd;
            if (se) begin
                m_state = 1;
                m_cnt   = 0;
                m_cs    = '0;
                m_ov    = 1'b0;
            end else if (de) begin
                if (m_state == 1) begin
                    m_mem[m_cnt] = in_data;
                    m_cs         = m_cs ^ in_data;
                    m_cnt        = m_cnt + 1;
                    if (m_cnt == PAGES) m_state = 2;
                end else begin
                    m_ov = 1'b1;
                end
            end
            m_ps = start;
            m_pd = in_done;
        end
        rd_q.push_back(exp_rd);
        @(posedge clk);
        #1;
        got = rd_q.pop_front();
        if (!$isunknown(got)) chk("rd_data", 32'(rd_data), 32'(got));
    endtask

    task automatic check_status(input string tag);
        chk({tag, ".page_count"}, 32'(page_count), 32'(m_cnt));
        chk({tag, ".checksum"},   32'(checksum),   32'(m_cs));
        chk({tag, ".full"},       32'(full),       32'(m_state == 2));
        chk({tag, ".busy"},       32'(busy),       32'(m_state == 1));
        chk({tag, ".overrun"},    32'(overrun),    32'(m_ov));
    endtask

    // Done held for 'hold' cycles; in_data changes after the edge cycle so
    // only the word present on the edge may be captured.
    task automatic pulse(input logic [WIDTH-1:0] word, input int hold);
        in_data = word;
        in_done = 1'b1;
        step();
        in_data = ~word;
        for (int k = 1; k < hold; k++) step();
        in_done = 1'b0;
        step();
    endtask

    task automatic start_edge();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    task automatic read_at(input int idx, input logic [WIDTH-1:0] exp, input string tag);
        rd_index = IDX_W'(idx);
        step();
        chk(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        for (int i = 0; i < PAGES; i++) m_mem[i] = 'x;
        reset    = 1'b1;
        start    = 1'b0;
        in_data  = '0;
        in_done  = 1'b0;
        rd_index = '0;
        m_ps = 1'b0; m_pd = 1'b0; m_state = 0; m_cnt = 0; m_cs = '0; m_ov = 1'b0;

        // 1: reset, full frame of words 0..63
        step();
        step();
        check_status("reset");
        chk("reset.rd_data", 32'(rd_data), 32'h0);
        reset = 1'b0;
        step();
        start_edge();
        check_status("t1.armed");
        for (int i = 0; i < PAGES; i++) begin
            pulse(WIDTH'(i), 1);
            if (i == PAGES - 2) check_status("t1.page63");
        end
        check_status("t1.full");
        chk("t1.full_const", 32'(full), 32'h1);
        chk("t1.count64", 32'(page_count), 32'd64);
        read_at(5, 25'd5, "t1.rd5");

        // 2: Done held 4 cycles, 64 pages of all-ones
        start_edge();
        for (int i = 0; i < PAGES; i++) pulse(25'h1FFFFFF, 4);
        check_status("t2.full");
        chk("t2.checksum0", 32'(checksum), 32'h0);
        read_at(17, 25'h1FFFFFF, "t2.rd17");

        // 3: extra Done in FULL sets overrun, buffer untouched; start clears it
        rd_index = '0;
        pulse(25'h0000123, 1);
        check_status("t3.overrun");
        chk("t3.overrun1", 32'(overrun), 32'h1);
        read_at(0, 25'h1FFFFFF, "t3.rd0");
        start_edge();
        check_status("t3.rearm");

        // 4: restart after 10 pages; next word lands at index 0 (read-first checked)
        for (int i = 0; i < 10; i++) pulse(WIDTH'(100 + i), 1);
        check_status("t4.ten");
        start_edge();
        check_status("t4.restart");
        rd_index = '0;
        pulse(25'h0ABC, 1);
        check_status("t4.one");
        read_at(0, 25'h0ABC, "t4.rd0");
        read_at(1, 25'd101, "t4.rd1_stale");

        // 5: coincident start and Done edges; then Done in IDLE after reset
        pulse(25'h0001, 1);
        start   = 1'b1;
        in_done = 1'b1;
        in_data = 25'h555;
        step();
        start   = 1'b0;
        in_done = 1'b0;
        step();
        check_status("t5.simul");
        chk("t5.count0", 32'(page_count), 32'h0);
        read_at(0, 25'h0ABC, "t5.rd0");
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        pulse(25'h777, 1);
        check_status("t5.idle_done");

        // 6: reset mid-frame at page 30
        start_edge();
        for (int i = 0; i < 30; i++) pulse(WIDTH'(32'h1000 + i), 1);
        check_status("t6.p30");
        reset = 1'b1;
        step();
        check_status("t6.reset");
        chk("t6.rd_data0", 32'(rd_data), 32'h0);
        reset = 1'b0;
        read_at(3, 25'h1003, "t6.rd3");
        check_status("t6.idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
